// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage definitions: datapath widths, FSM state encodings
// and the timeout-counter sizing helper.
package wb_stage_pkg;

  localparam int WORD_WIDTH           = 32;
  localparam int REG_FILE_DEPTH       = 4;
  localparam int LOAD_TIMEOUT_DEFAULT = 15;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM result onto the register-file write port,
// stalling upstream while a load waits on data memory, with a timeout abort.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic                      mem_WB_en,
  input  logic                      mem_R_en,
  input  logic [REG_FILE_DEPTH-1:0] mem_dest,
  input  logic [WORD_WIDTH-1:0]     mem_alu_res,
  input  logic [WORD_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_rvalid,
  output logic                      mem_stall,
  output logic                      WB_en,
  output logic [REG_FILE_DEPTH-1:0] WB_dest,
  output logic [WORD_WIDTH-1:0]     WB_result,
  output logic                      dmem_err
);

  localparam int                 CNT_W   = cnt_width(LOAD_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(LOAD_TIMEOUT);

  wb_state_e                 r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_wb_en;
  logic [REG_FILE_DEPTH-1:0] r_wb_dest;
  logic [WORD_WIDTH-1:0]     r_wb_result;
  logic                      r_dmem_err;
  logic                      w_timeout;
  logic                      w_stall;

  // A waiting load stalls until data arrives, a flush, or the timeout cycle.
  always_comb begin
    w_timeout = (r_cnt == CNT_MAX);
    w_stall   = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (mem_valid && mem_R_en && !dmem_rvalid) w_stall = 1'b1;
        else                                        w_stall = 1'b0;
      end
      WB_LOAD_WAIT: begin
        if (mem_valid && !dmem_rvalid && !w_timeout) w_stall = 1'b1;
        else                                          w_stall = 1'b0;
      end
      default: w_stall = 1'b0;
    endcase
  end

  // Writeback FSM, timeout counter and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= WB_IDLE;
      r_cnt       <= '0;
      r_wb_en     <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_result <= '0;
      r_dmem_err  <= 1'b0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (!mem_valid) begin
            r_wb_en <= 1'b0;
          end else if (!mem_R_en) begin
            r_wb_en     <= mem_WB_en;
            r_wb_dest   <= mem_dest;
            r_wb_result <= mem_alu_res;
          end else if (dmem_rvalid) begin
            r_wb_en     <= mem_WB_en;
            r_wb_dest   <= mem_dest;
            r_wb_result <= dmem_rdata;
          end else begin
            r_wb_en <= 1'b0;
            r_state <= WB_LOAD_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        WB_LOAD_WAIT: begin
          r_wb_en <= 1'b0;
          if (!mem_valid) begin
            r_state <= WB_IDLE;
            r_cnt   <= '0;
          end else if (dmem_rvalid) begin
            r_wb_en     <= mem_WB_en;
            r_wb_dest   <= mem_dest;
            r_wb_result <= dmem_rdata;
            r_state     <= WB_IDLE;
            r_cnt       <= '0;
          end else if (w_timeout) begin
            // Memory never answered: drop the load and flag it permanently.
            r_dmem_err <= 1'b1;
            r_state    <= WB_IDLE;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_wb_en <= 1'b0;
          r_state <= WB_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign mem_stall = w_stall;
  assign WB_en     = r_wb_en;
  assign WB_dest   = r_wb_dest;
  assign WB_result = r_wb_result;
  assign dmem_err  = r_dmem_err;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int TMO = 4;

  logic                      clk;
  logic                      rst;
  logic                      mem_valid;
  logic                      mem_WB_en;
  logic                      mem_R_en;
  logic [REG_FILE_DEPTH-1:0] mem_dest;
  logic [WORD_WIDTH-1:0]     mem_alu_res;
  logic [WORD_WIDTH-1:0]     dmem_rdata;
  logic                      dmem_rvalid;
  logic                      mem_stall;
  logic                      WB_en;
  logic [REG_FILE_DEPTH-1:0] WB_dest;
  logic [WORD_WIDTH-1:0]     WB_result;
  logic                      dmem_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: what the write port must show, and how long the current load has stalled.
  logic                      exp_en;
  logic [REG_FILE_DEPTH-1:0] exp_dest;
  logic [WORD_WIDTH-1:0]     exp_res;
  logic                      exp_err;
  bit                        m_waiting;
  int                        m_stalled;

  wb_stage #(.LOAD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_WB_en(mem_WB_en),
    .mem_R_en(mem_R_en), .mem_dest(mem_dest), .mem_alu_res(mem_alu_res),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .mem_stall(mem_stall),
    .WB_en(WB_en), .WB_dest(WB_dest), .WB_result(WB_result), .dmem_err(dmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_en    = 1'b0;
    exp_dest  = '0;
    exp_res   = '0;
    exp_err   = 1'b0;
    m_waiting = 1'b0;
    m_stalled = 0;
  endfunction

  // A presented load without data stalls, unless it has already stalled TMO cycles.
  function automatic logic model_stall();
    if (!mem_valid)  return 1'b0;
    if (dmem_rvalid) return 1'b0;
    if (m_waiting)   return (m_stalled < TMO);
    return mem_R_en;
  endfunction

  function automatic void model_step();
    if (!mem_valid) begin
      exp_en = 1'b0; m_waiting = 1'b0; m_stalled = 0;
    end else if (!m_waiting && !mem_R_en) begin
      exp_en = mem_WB_en; exp_dest = mem_dest; exp_res = mem_alu_res;
    end else if (dmem_rvalid) begin
      exp_en = mem_WB_en; exp_dest = mem_dest; exp_res = dmem_rdata;
      m_waiting = 1'b0; m_stalled = 0;
    end else if (m_waiting && m_stalled >= TMO) begin
      exp_en = 1'b0; exp_err = 1'b1; m_waiting = 1'b0; m_stalled = 0;
    end else begin
      exp_en = 1'b0; m_waiting = 1'b1; m_stalled++;
    end
  endfunction

  // Every falling edge: compare DUT against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_WB_en", {63'd0, WB_en}, {63'd0, exp_en});
      chk("m_WB_dest", {60'd0, WB_dest}, {60'd0, exp_dest});
      chk("m_WB_result", {32'd0, WB_result}, {32'd0, exp_res});
      chk("m_dmem_err", {63'd0, dmem_err}, {63'd0, exp_err});
      chk("m_mem_stall", {63'd0, mem_stall}, {63'd0, model_stall()});
      model_step();
    end
  end

  task automatic present(input logic v, input logic we, input logic re,
                         input logic [REG_FILE_DEPTH-1:0] d, input logic [WORD_WIDTH-1:0] res,
                         input logic rv, input logic [WORD_WIDTH-1:0] rd);
    @(posedge clk); #2;
    mem_valid = v; mem_WB_en = we; mem_R_en = re; mem_dest = d;
    mem_alu_res = res; dmem_rvalid = rv; dmem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_WB_en = 1'b0; mem_R_en = 1'b0; mem_dest = 4'd0;
    mem_alu_res = 32'd0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    idle_inputs();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_WB_en", {63'd0, WB_en}, 64'd0);
    chk("rst_WB_dest", {60'd0, WB_dest}, 64'd0);
    chk("rst_WB_result", {32'd0, WB_result}, 64'd0);
    chk("rst_dmem_err", {63'd0, dmem_err}, 64'd0);
    chk("rst_mem_stall", {63'd0, mem_stall}, 64'd0);
    #1 rst = 1'b1;
  endtask

  task automatic alu_scenario();
    present(1'b1, 1'b1, 1'b0, 4'd3, 32'h1234, 1'b0, 32'd0);
    chk("alu_stall", {63'd0, mem_stall}, 64'd0);
    present(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("alu_WB_en", {63'd0, WB_en}, 64'd1);
    chk("alu_WB_dest", {60'd0, WB_dest}, 64'd3);
    chk("alu_WB_result", {32'd0, WB_result}, 64'h1234);
  endtask

  int n_stall;

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("init_WB_en", {63'd0, WB_en}, 64'd0);
    chk("init_WB_result", {32'd0, WB_result}, 64'd0);
    chk("init_dmem_err", {63'd0, dmem_err}, 64'd0);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    alu_scenario();

    // Zero-wait load
    present(1'b1, 1'b1, 1'b1, 4'd5, 32'hABC, 1'b1, 32'hCAFE);
    chk("zw_stall", {63'd0, mem_stall}, 64'd0);
    present(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("zw_WB_en", {63'd0, WB_en}, 64'd1);
    chk("zw_WB_dest", {60'd0, WB_dest}, 64'd5);
    chk("zw_WB_result", {32'd0, WB_result}, 64'hCAFE);

    // Load with data three cycles late, then a back-to-back ALU op
    n_stall = 0;
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 1'b1, 1'b1, 4'd5, 32'h40, 1'b0, 32'd0);
      if (mem_stall) n_stall++;
      if (i > 0) chk("w3_bubble", {63'd0, WB_en}, 64'd0);
    end
    present(1'b1, 1'b1, 1'b1, 4'd5, 32'h40, 1'b1, 32'hBEEF);
    chk("w3_bubble", {63'd0, WB_en}, 64'd0);
    if (mem_stall) n_stall++;
    chk("w3_stall_cycles", n_stall, 64'd3);
    present(1'b1, 1'b1, 1'b0, 4'd7, 32'h77, 1'b0, 32'd0);
    chk("w3_WB_en", {63'd0, WB_en}, 64'd1);
    chk("w3_WB_dest", {60'd0, WB_dest}, 64'd5);
    chk("w3_WB_result", {32'd0, WB_result}, 64'hBEEF);
    present(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("b2b_WB_dest", {60'd0, WB_dest}, 64'd7);
    chk("b2b_WB_result", {32'd0, WB_result}, 64'h77);

    // Flush while waiting, then a spurious rvalid
    present(1'b1, 1'b1, 1'b1, 4'd2, 32'h80, 1'b0, 32'd0);
    chk("fl_stall_on", {63'd0, mem_stall}, 64'd1);
    present(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("fl_stall_off", {63'd0, mem_stall}, 64'd0);
    present(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 32'hDEAD);
    chk("fl_WB_en", {63'd0, WB_en}, 64'd0);
    present(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("fl_WB_en2", {63'd0, WB_en}, 64'd0);
    chk("fl_WB_result", {32'd0, WB_result}, 64'h77);
    chk("fl_dmem_err", {63'd0, dmem_err}, 64'd0);

    // Async reset between edges while a load is waiting
    present(1'b1, 1'b1, 1'b1, 4'd4, 32'h90, 1'b0, 32'd0);
    pulse_reset();
    alu_scenario();

    // Randomized traffic; a stalled instruction is held unless flushed
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      if (m_waiting) begin
        mem_valid = ($urandom_range(9) != 0);
      end else begin
        mem_valid   = ($urandom_range(4) != 0);
        mem_WB_en   = 1'($urandom);
        mem_R_en    = ($urandom_range(2) == 0);
        mem_dest    = 4'($urandom);
        mem_alu_res = $urandom;
      end
      dmem_rvalid = ($urandom_range(3) == 0);
      dmem_rdata  = $urandom;
    end

    // Timeout: memory never answers
    pulse_reset();
    n_stall = 0;
    for (int i = 0; i <= TMO; i++) begin
      present(1'b1, 1'b1, 1'b1, 4'd9, 32'hA0, 1'b0, 32'd0);
      if (mem_stall) n_stall++;
    end
    chk("to_release", {63'd0, mem_stall}, 64'd0);
    chk("to_err_before", {63'd0, dmem_err}, 64'd0);
    chk("to_stall_cycles", n_stall, TMO);
    present(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("to_WB_en", {63'd0, WB_en}, 64'd0);
    chk("to_dmem_err", {63'd0, dmem_err}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 1'b1, 1'b0, 4'd1, 32'h11, 1'b1, 32'd0);
      chk("to_err_sticky", {63'd0, dmem_err}, 64'd1);
    end

    @(posedge clk); #2;
    idle_inputs();
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
